// File: rtl/multi_clock_divider.sv
// Multi-channel clock/tick divider running from the 100MHz board clock.
// Each lane has a double-buffered divide value, its own enable and its own square/tick mode.

module multi_clock_divider_lane #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock_100MHz,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 load,
  input  logic                 restart,
  input  logic [CNT_WIDTH-1:0] div_value,
  output logic                 clock_divided,
  output logic                 terminal
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] shadow;
  logic [CNT_WIDTH-1:0] active;
  logic                 wrap;

  assign wrap = (cnt == active);

  // Shadow capture is independent of restart/enable so a load is never lost.
  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n)  shadow <= '0;
    else if (load) shadow <= div_value;
  end

  // Active N only changes on a wrap or while idle, so a running period always
  // completes with the value it started with.
  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      active        <= '0;
      clock_divided <= 1'b0;
      terminal      <= 1'b0;
    end else if (restart) begin
      cnt           <= '0;
      clock_divided <= 1'b0;
      terminal      <= 1'b0;
    end else if (!enable) begin
      cnt           <= '0;
      active        <= shadow;
      clock_divided <= 1'b0;
      terminal      <= 1'b0;
    end else if (wrap) begin
      cnt           <= '0;
      active        <= shadow;
      terminal      <= 1'b1;
      clock_divided <= mode ? 1'b1 : ~clock_divided;
    end else begin
      cnt      <= cnt + 1'b1;
      terminal <= 1'b0;
      if (mode) clock_divided <= 1'b0;
    end
  end

endmodule

module multi_clock_divider #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clock_100MHz,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0]             enable,
  input  logic [NUM_CH-1:0]             mode,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   div_count_value,
  input  logic [NUM_CH-1:0]             load,
  input  logic                          restart,
  output logic [NUM_CH-1:0]             clock_divided,
  output logic [NUM_CH-1:0]             terminal
);

  logic [NUM_CH-1:0][CNT_WIDTH-1:0] div_slices;

  assign div_slices = div_count_value;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    multi_clock_divider_lane #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clock_100MHz  (clock_100MHz),
      .reset_n       (reset_n),
      .enable        (enable[i]),
      .mode          (mode[i]),
      .load          (load[i]),
      .restart       (restart),
      .div_value     (div_slices[i]),
      .clock_divided (clock_divided[i]),
      .terminal      (terminal[i])
    );
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised, multi-channel successor to the single-output clock divider; derives NUM_CH independent slow clocks/ticks from the board 100MHz clock.
- Each channel has its own divide value, enable and output mode (50% square wave or one-cycle tick).
- Divide values are double-buffered so they change glitch-free; a global restart phase-aligns all channels.
- Feeds display multiplexing, debouncing and calculator sequencing logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (>=1).
- CNT_WIDTH, 32, width of each channel counter and divide value.

Ports:
- clock_100MHz  input  1  100MHz board clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  NUM_CH  per-channel run enable, bit i = channel i.
- mode  input  NUM_CH  per-channel mode: 0 = square wave, 1 = tick.
- div_count_value  input  NUM_CH*CNT_WIDTH  terminal counts N; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- load  input  NUM_CH  per-channel strobe capturing div_count_value slice into the shadow register.
- restart  input  1  synchronous strobe: zero every counter and output together.
- clock_divided  output  NUM_CH  registered divided clock or tick per channel.
- terminal  output  NUM_CH  registered one-cycle pulse each time channel i wraps, independent of mode.

Behaviour:
- Reset (reset_n low, async): counters, shadow and active divide registers = 0; clock_divided = 0; terminal = 0. Held until reset_n rises; first count on the first clock edge after deassertion.
- Priority per channel, per edge: reset_n > restart > enable low > normal count.
- Normal count:
  - counter runs 0..N_active.
  - On the edge where counter == N_active: counter <= 0; terminal[i] <= 1 for exactly one cycle.
  - Mode 0: clock_divided[i] toggles on that edge. Period = 2*(N+1) clocks, 50% duty.
  - Mode 1: clock_divided[i] = 1 for that single cycle, else 0. Period = N+1 clocks.
  - Otherwise counter increments, terminal <= 0; in mode 1 clock_divided <= 0.
- Output latency: outputs change on the same edge the counter wraps; all outputs are registered, no combinational paths from inputs.
- N = 0: mode 0 toggles every cycle (50MHz); mode 1 and terminal stay high continuously.
- Double buffering:
  - load[i] high at an edge captures the slice into shadow[i].
  - shadow[i] is copied to active N[i] only on the wrap edge, or on any edge while enable[i] is low.
  - A period in progress therefore always completes with the old N.
  - load coinciding with a wrap edge: the new value is captured in shadow and applied at the following wrap, not the current one.
  - Repeated loads before a wrap: the last one wins.
- Disable (enable[i] low):
  - counter <= 0, clock_divided[i] <= 0, terminal[i] <= 0.
  - active <= shadow on each disabled edge.
  - On re-enable, the channel restarts from counter 0 with output low.
- Mode change mid-period: takes effect at the next edge. Switching 0->1 forces the output low until the next wrap; switching 1->0 holds the current level until the next wrap.
- restart:
  - Zeroes all counters, clock_divided and terminal on that edge.
  - Does not alter shadow/active values; load on the same edge is still captured.
  - Enabled channels with equal N are then phase-identical.
- Counter arithmetic: unsigned, CNT_WIDTH bits. N = 2^CNT_WIDTH-1 is legal; the counter never overflows because it wraps at N.
- Async reset mid-period: immediate clear regardless of clock, including while restart or load is high.

Test Plan:
- Reset: assert reset_n=0 mid-count on all channels -> clock_divided=0000, terminal=0000 immediately, without a clock edge; first wrap occurs N+1 edges after release.
- Square wave: ch0 N=2, mode 0, enabled -> clock_divided[0] toggles every 3 clocks (period 6); terminal[0] pulses every 3 clocks.
- Tick and N=0: ch1 N=4, mode 1 -> one-cycle pulse every 5 clocks; ch2 N=0, mode 1 -> output constantly 1; ch2 N=0, mode 0 -> toggles every clock.
- Glitch-free reload: ch0 N=9, load N=1 at counter=3 -> current period completes at count 9, then the output toggles every 2 clocks; a load on the wrap edge is applied one period later.
- Enable/restart: drop enable[3] at counter=5 -> output 0 and counter 0 next edge; re-enable -> first wrap N+1 clocks later. Pulse restart with ch0 and ch1 both at N=7 and different phases -> identical outputs thereafter.
- Width/parameter: NUM_CH=1, CNT_WIDTH=4, N=15 -> 32-clock period, no overflow; default build with N=833333 -> ~60Hz (period 1,666,668 clocks).
